// File: rtl/cost_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cost_pkg
//  Description : Shared constants and FSM state encoding for the cost table.
//                Optional feature macro: COST_TABLE_CHECKSUM_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package cost_pkg;

  localparam int N_SIDE  = 8;
  localparam int N_ENTRY = N_SIDE * N_SIDE;
  localparam int COST_W  = 7;
  localparam int IDX_W   = $clog2(N_ENTRY);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

endpackage : cost_pkg
`default_nettype wire

// File: rtl/cost_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : cost_regfile
//  Description : Cost entry storage, one write port and one registered read
//                port. Contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module cost_regfile
  import cost_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port: store the accepted entry at the load address.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: one-cycle registered lookup (read-before-write on collision).
  always_ff @(posedge clk) begin
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule : cost_regfile
`default_nettype wire

// File: rtl/cost_table.sv
`default_nettype none
// ============================================================================
//  Module      : cost_table
//  Description : 8x8 worker/job cost table. Loaded serially through a
//                valid/ready port, then looked up by (W, J) with one cycle
//                latency. Define COST_TABLE_CHECKSUM_EN to add a running
//                checksum output of all accepted entries.
//  Revision    : 1.0  initial release
// ============================================================================
module cost_table
  import cost_pkg::*;
#(
  parameter int COST_W = cost_pkg::COST_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [COST_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic              loaded
`ifdef COST_TABLE_CHECKSUM_EN
  ,
  output logic [COST_W+5:0] checksum
`endif
);

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_load_cnt;
  logic               r_cost_valid;
  logic               w_accept;
  logic               w_last;
  logic [COST_W-1:0]  w_rd_data;

  // A reload in the same cycle as in_valid drops the entry.
  assign w_accept = in_valid && in_ready && !reload;
  assign w_last   = (r_load_cnt == IDX_W'(N_ENTRY - 1));
  assign in_ready = (r_state != READY);
  assign loaded   = (r_state == READY);

  // Lookup output is forced to zero until a READY-state read has been issued.
  assign Cost     = r_cost_valid ? w_rd_data : '0;

  cost_regfile #(
    .DATA_W (COST_W),
    .DEPTH  (N_ENTRY),
    .ADDR_W (IDX_W)
  ) u_regfile (
    .clk       (CLK),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_load_cnt),
    .i_wr_data (in_data),
    .i_rd_addr ({W, J}),
    .o_rd_data (w_rd_data)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: reload dominates, load completes on the 64th accept.
  always_comb begin
    w_next = r_state;
    if (reload) begin
      w_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_accept) w_next = w_last ? READY : LOAD;
        LOAD:    if (w_accept && w_last) w_next = READY;
        READY:   w_next = READY;
        default: w_next = EMPTY;
      endcase
    end
  end

  // Load address counter; wraps to zero after the last entry.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_load_cnt <= '0;
    end else if (reload) begin
      r_load_cnt <= '0;
    end else if (w_accept) begin
      r_load_cnt <= r_load_cnt + IDX_W'(1);
    end
  end

  // Marks that the registered read data is a valid READY-state lookup.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cost_valid <= 1'b0;
    end else begin
      r_cost_valid <= (r_state == READY) && !reload;
    end
  end

`ifdef COST_TABLE_CHECKSUM_EN
  logic [COST_W+5:0] r_checksum;

  // Running sum of accepted entries; wide enough for 64 maximum-value entries.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_checksum <= '0;
    end else if (reload) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + (COST_W+6)'(in_data);
    end
  end

  assign checksum = r_checksum;
`endif

endmodule : cost_table
`default_nettype wire
